// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: glyph table (active-low {g,f,e,d,c,b,a}) used by
// both the display driver's encoder and the scan decoder, plus anode helpers.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_A     = 7'b0001000;
  localparam logic [6:0] GLYPH_B     = 7'b0000011;
  localparam logic [6:0] GLYPH_C     = 7'b1000110;
  localparam logic [6:0] GLYPH_D     = 7'b0100001;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_F     = 7'b0001110;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    AN_BLANK,
    AN_ONE,
    AN_MULTI
  } an_class_e;

  // Active-low anode vector: no digit, exactly one digit, or a driver fault.
  function automatic an_class_e classify_an(input logic [NUM_DIGITS-1:0] an_n);
    int unsigned lows;
    lows = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_n[i]) lows++;
    end
    if (lows == 0) return AN_BLANK;
    if (lows == 1) return AN_ONE;
    return AN_MULTI;
  endfunction

  function automatic logic [6:0] glyph_of(input logic [3:0] nibble);
    case (nibble)
      4'h0: return GLYPH_0;
      4'h1: return GLYPH_1;
      4'h2: return GLYPH_2;
      4'h3: return GLYPH_3;
      4'h4: return GLYPH_4;
      4'h5: return GLYPH_5;
      4'h6: return GLYPH_6;
      4'h7: return GLYPH_7;
      4'h8: return GLYPH_8;
      4'h9: return GLYPH_9;
      4'hA: return GLYPH_A;
      4'hB: return GLYPH_B;
      4'hC: return GLYPH_C;
      4'hD: return GLYPH_D;
      4'hE: return GLYPH_E;
      default: return GLYPH_F;
    endcase
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational inverse of the glyph table: segment pattern -> hex nibble.
// Unknown patterns (including blank) flag bad and return nibble 0.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       bad_o
);

  always_comb begin
    nibble_o = 4'h0;
    bad_o    = 1'b0;
    case (seg_i)
      GLYPH_0: nibble_o = 4'h0;
      GLYPH_1: nibble_o = 4'h1;
      GLYPH_2: nibble_o = 4'h2;
      GLYPH_3: nibble_o = 4'h3;
      GLYPH_4: nibble_o = 4'h4;
      GLYPH_5: nibble_o = 4'h5;
      GLYPH_6: nibble_o = 4'h6;
      GLYPH_7: nibble_o = 4'h7;
      GLYPH_8: nibble_o = 4'h8;
      GLYPH_9: nibble_o = 4'h9;
      GLYPH_A: nibble_o = 4'hA;
      GLYPH_B: nibble_o = 4'hB;
      GLYPH_C: nibble_o = 4'hC;
      GLYPH_D: nibble_o = 4'hD;
      GLYPH_E: nibble_o = 4'hE;
      GLYPH_F: nibble_o = 4'hF;
      default: bad_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed 7-segment bus and rebuilds the displayed 16-bit value,
// one frame per complete 4-digit scan, with glyph/anode/stall error reporting.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2**20,
  parameter int CNT_BITS       = 21
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic                    dp,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   dp_mask,
  output logic                    frame_valid,
  output logic                    frame_err,
  output logic                    anode_err,
  output logic                    stalled
);

  localparam int SMP_W = NUM_DIGITS + 7 + 1;
  localparam logic [CNT_BITS-1:0] SETTLE_MAX = CNT_BITS'(SETTLE_CYCLES);
  localparam logic [CNT_BITS-1:0] SETTLE_HIT = CNT_BITS'(SETTLE_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] TMO_MAX    = CNT_BITS'(TIMEOUT_CYCLES);
  localparam logic [CNT_BITS-1:0] TMO_HIT    = CNT_BITS'(TIMEOUT_CYCLES - 1);

  logic [SMP_W-1:0]        sync1_q, sync2_q, prev_q;
  logic [CNT_BITS-1:0]     stab_q, stab_d, tmo_q, tmo_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [NUM_DIGITS-1:0]   dp_slot_q, dp_slot_d, bad_slot_q, bad_slot_d;
  logic [4*NUM_DIGITS-1:0] nib_slot_q, nib_slot_d;
  logic                    complete_q, complete_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   dp_mask_q, dp_mask_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    frame_err_q, frame_err_d;
  logic                    anode_err_q, anode_err_d;
  logic                    stalled_q, stalled_d;

  logic [NUM_DIGITS-1:0]   smp_an, sel, seen_acc;
  logic [6:0]              smp_seg;
  logic                    smp_dp;
  logic [3:0]              dec_nib;
  logic                    dec_bad;
  logic                    match, accept, acc_one, acc_multi, completes, timeout_hit;
  an_class_e               an_cls;

  assign smp_an  = prev_q[SMP_W-1 -: NUM_DIGITS];
  assign smp_seg = prev_q[7:1];
  assign smp_dp  = prev_q[0];

  seg7_glyph_decode u_glyph (
    .seg_i    (smp_seg),
    .nibble_o (dec_nib),
    .bad_o    (dec_bad)
  );

  always_comb begin
    match  = (sync2_q == prev_q);
    stab_d = '0;
    if (match) stab_d = (stab_q == SETTLE_MAX) ? stab_q : stab_q + 1'b1;
    // One accept per dwell: only the cycle the counter crosses into saturation.
    accept    = match && (stab_q == SETTLE_HIT);
    an_cls    = classify_an(smp_an);
    acc_one   = accept && (an_cls == AN_ONE);
    acc_multi = accept && (an_cls == AN_MULTI);
    sel       = ~smp_an;
    seen_acc  = seen_q | sel;
    completes = acc_one && (&seen_acc);
    timeout_hit = !complete_q && !completes && (tmo_q == TMO_HIT);

    nib_slot_d = nib_slot_q;
    dp_slot_d  = dp_slot_q;
    bad_slot_d = bad_slot_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (acc_one && sel[i]) begin
        nib_slot_d[4*i +: 4] = dec_nib;
        dp_slot_d[i]         = ~smp_dp;
        bad_slot_d[i]        = dec_bad;
      end
    end

    seen_d = seen_q;
    if (completes)                      seen_d = seen_acc;
    else if (complete_q || timeout_hit) seen_d = acc_one ? sel : '0;
    else if (acc_one)                   seen_d = seen_acc;

    complete_d = completes;

    tmo_d = tmo_q;
    if (complete_q)          tmo_d = '0;
    else if (timeout_hit)    tmo_d = TMO_MAX;
    else if (tmo_q < TMO_HIT) tmo_d = tmo_q + 1'b1;

    stalled_d = stalled_q;
    if (complete_q)       stalled_d = 1'b0;
    else if (timeout_hit) stalled_d = 1'b1;

    anode_err_d   = anode_err_q | acc_multi;
    frame_valid_d = complete_q;
    value_d       = value_q;
    dp_mask_d     = dp_mask_q;
    frame_err_d   = frame_err_q;
    // Slots were written on the completing accept; publish them one cycle later.
    if (complete_q) begin
      value_d     = nib_slot_q;
      dp_mask_d   = dp_slot_q;
      frame_err_d = |bad_slot_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q       <= '1;
      sync2_q       <= '1;
      prev_q        <= '1;
      stab_q        <= '0;
      tmo_q         <= '0;
      seen_q        <= '0;
      complete_q    <= 1'b0;
      value_q       <= '0;
      dp_mask_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      anode_err_q   <= 1'b0;
      stalled_q     <= 1'b0;
    end else begin
      sync1_q       <= {an, seg, dp};
      sync2_q       <= sync1_q;
      prev_q        <= sync2_q;
      stab_q        <= stab_d;
      tmo_q         <= tmo_d;
      seen_q        <= seen_d;
      complete_q    <= complete_d;
      value_q       <= value_d;
      dp_mask_q     <= dp_mask_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      anode_err_q   <= anode_err_d;
      stalled_q     <= stalled_d;
    end
  end

  // Slot contents are only meaningful under the seen mask, so they carry no reset.
  always_ff @(posedge clk) begin
    nib_slot_q <= nib_slot_d;
    dp_slot_q  <= dp_slot_d;
    bad_slot_q <= bad_slot_d;
  end

  assign value       = value_q;
  assign dp_mask     = dp_mask_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign anode_err   = anode_err_q;
  assign stalled     = stalled_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomized bench for seg7_scan_decoder with a dwell-level reference model and frame scoreboard.
module tb_seg7_scan_decoder;

  localparam int S  = 16;
  localparam int T  = 2000;
  localparam int CB = 21;
  localparam logic [6:0] GL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
    7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        frame_valid, frame_err, anode_err, stalled;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T), .CNT_BITS(CB)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .seg         (seg),
    .an          (an),
    .dp          (dp),
    .value       (value),
    .dp_mask     (dp_mask),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .anode_err   (anode_err),
    .stalled     (stalled)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: state of the receiver after each accepted digit dwell.
  typedef struct {
    logic [15:0] v;
    logic [3:0]  dpm;
    logic        fe;
  } frame_t;

  int          m_nib [4];
  bit          m_dp [4];
  bit          m_bad [4];
  bit          m_seen [4];
  bit          m_anode_err;
  logic [15:0] m_last_value;
  frame_t      exp_q [$];
  frame_t      mon_f;
  int          frames_seen;

  task automatic model_clear_seen();
    for (int i = 0; i < 4; i++) m_seen[i] = 0;
  endtask

  task automatic model_accept(input logic [3:0] a, input logic [6:0] s, input logic d);
    int lows, idx;
    frame_t f;
    lows = 0;
    idx  = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) begin lows++; idx = i; end
    if (lows == 0) return;
    if (lows > 1) begin m_anode_err = 1; return; end
    m_nib[idx] = 0;
    m_bad[idx] = 1;
    for (int k = 0; k < 16; k++) if (GL[k] == s) begin m_nib[idx] = k; m_bad[idx] = 0; end
    m_dp[idx]   = !d;
    m_seen[idx] = 1;
    if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
      f.v   = 16'(m_nib[3] * 4096 + m_nib[2] * 256 + m_nib[1] * 16 + m_nib[0]);
      f.dpm = {m_dp[3], m_dp[2], m_dp[1], m_dp[0]};
      f.fe  = m_bad[0] | m_bad[1] | m_bad[2] | m_bad[3];
      exp_q.push_back(f);
      m_last_value = f.v;
      model_clear_seen();
    end
  endtask

  // Callers are at a negedge; dwell counts clock cycles the pattern is held.
  task automatic show(input logic [3:0] a, input logic [6:0] s, input logic d, input int dwell);
    an  = a;
    seg = s;
    dp  = d;
    if (dwell >= S + 3) model_accept(a, s, d);
    repeat (dwell) @(negedge clk);
  endtask

  function automatic logic [3:0] anv(input int i);
    logic [3:0] r;
    r    = 4'hF;
    r[i] = 1'b0;
    return r;
  endfunction

  task automatic digit(input int i, input logic [3:0] n, input logic lit);
    show(anv(i), GL[n], !lit, S + 10);
  endtask

  task automatic gap();
    show(4'hF, 7'h7F, 1'b1, 2);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("frame_drain_pending", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && frame_valid === 1'b1) begin
      frames_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 1, 0);
      end else begin
        mon_f = exp_q.pop_front();
        check("value", value, mon_f.v);
        check("dp_mask", dp_mask, mon_f.dpm);
        check("frame_err", frame_err, mon_f.fe);
        check("stalled_on_frame", stalled, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int lat, fs;
    logic [3:0] n;
    logic [6:0] g;
    logic lit;
    frames_seen  = 0;
    m_anode_err  = 0;
    m_last_value = 16'h0;
    model_clear_seen();
    reset_n = 1'b0;
    an  = 4'hF;
    seg = 7'h7F;
    dp  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_value", value, 0);
    check("rst_dp_mask", dp_mask, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_anode_err", anode_err, 0);
    check("rst_stalled", stalled, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: clean scan of 1234, with latency measured on the last digit.
    digit(3, 4'h1, 0);
    digit(2, 4'h2, 0);
    digit(1, 4'h3, 0);
    an = 4'b1110; seg = GL[4]; dp = 1'b1;
    model_accept(4'b1110, GL[4], 1'b1);
    lat = 0;
    while (frame_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, S + 4);
    repeat (8) @(negedge clk);
    gap();
    drain();

    // 2: blank glyph on one digit forces a zero nibble and frame_err.
    digit(3, 4'h5, 0);
    digit(2, 4'hA, 1);
    show(anv(1), 7'h7F, 1'b1, S + 10);
    digit(0, 4'hF, 0);
    gap();
    drain();

    // 3: two anodes low is an anode fault, sticky across good frames.
    show(4'b0011, GL[8], 1'b1, 40);
    check("anode_err_set", anode_err, m_anode_err);
    for (int i = 3; i >= 0; i--) digit(i, 4'(i + 6), 0);
    gap();
    drain();
    check("anode_err_sticky", anode_err, 1);

    // 4: a glitch shorter than the settle window inside a digit dwell.
    digit(3, 4'h7, 0);
    digit(2, 4'hF, 0);
    digit(1, 4'h3, 0);
    show(anv(1), 7'b0000000, 1'b1, S - 1);
    check("glitch_value_held", value, m_last_value);
    digit(1, 4'h3, 0);
    digit(0, 4'hC, 1);
    gap();
    drain();

    // Randomized scans: bad glyphs, overwritten digits and glitches.
    for (int f = 0; f < 20; f++) begin
      for (int i = 3; i >= 0; i--) begin
        n   = 4'($urandom_range(0, 15));
        lit = 1'($urandom_range(0, 1));
        g   = GL[n];
        if ($urandom_range(0, 7) == 0) g = 7'($urandom);
        if ($urandom_range(0, 5) == 0) show(anv(i), GL[4'(n + 1)], lit, S + 6);
        show(anv(i), g, !lit, S + 10);
        if ($urandom_range(0, 5) == 0) begin
          show(anv(i), ~g, !lit, S - 1);
          show(anv(i), g, !lit, S + 10);
        end
      end
      gap();
    end
    drain();
    check("anode_err_after_random", anode_err, m_anode_err);

    // 5: scanning stops long enough to stall; partial digits must be forgotten.
    digit(0, 4'h9, 1);
    digit(1, 4'h9, 1);
    show(4'hF, 7'h7F, 1'b1, T + 60);
    model_clear_seen();
    check("stalled_set", stalled, 1);
    fs = frames_seen;
    digit(3, 4'h0, 0);
    digit(2, 4'h0, 0);
    gap();
    repeat (S + 10) @(negedge clk);
    check("no_frame_after_stall", frames_seen, fs);
    check("stalled_held", stalled, 1);
    digit(1, 4'hF, 0);
    digit(0, 4'h0, 0);
    gap();
    drain();
    check("stalled_cleared", stalled, 0);
    check("frames_after_stall", frames_seen, fs + 1);

    // 6: reset in the middle of a frame discards the partial scan.
    digit(3, 4'h8, 0);
    digit(2, 4'h4, 0);
    digit(1, 4'h2, 0);
    reset_n = 1'b0;
    an  = 4'hF;
    seg = 7'h7F;
    dp  = 1'b1;
    #1;
    check("midrst_value", value, 0);
    check("midrst_dp_mask", dp_mask, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_anode_err", anode_err, 0);
    check("midrst_stalled", stalled, 0);
    m_anode_err = 0;
    model_clear_seen();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    fs = frames_seen;
    digit(0, 4'h1, 0);
    gap();
    repeat (S + 10) @(negedge clk);
    check("no_frame_after_reset", frames_seen, fs);
    for (int i = 3; i >= 0; i--) digit(i, 4'(2 * i + 1), 1);
    gap();
    drain();
    check("frames_after_reset", frames_seen, fs + 1);
    check("anode_err_final", anode_err, m_anode_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
